mem_in_burst_scheduler: RTL
===========================

MEM_IN_BURST_SCHEDULER -- requirements
Module: mem_in_burst_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one input-memory burst reader.
REQ-002 The block SHALL have parameter log2_DEPTH, default 3: width of the burst-length field, matching the reader's num_of_dat.
REQ-003 The block SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, NUM_REQ: per-requester burst request level.
REQ-006 The block SHALL have port req_len, input, NUM_REQ*log2_DEPTH: per-requester last word index; requester i uses bits [i*log2_DEPTH +: log2_DEPTH]; burst = len+1 words.
REQ-007 The block SHALL have port grant, output, NUM_REQ: one-hot owner of the reader, held for the whole burst.
REQ-008 The block SHALL have port req_done, output, NUM_REQ: one-cycle pulse to the owner at burst end.
REQ-009 The block SHALL have port mem_start, output, 1: one-cycle start pulse to the reader.
REQ-010 The block SHALL have port mem_num_of_dat, output, log2_DEPTH: burst length to the reader, stable from mem_start through mem_done.
REQ-011 The block SHALL have port mem_done, input, 1: reader end-of-burst pulse.
REQ-012 The block SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 The block SHALL have port timeout_err, output, 1: sticky watchdog flag (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and GAP; all outputs SHALL be registered.
REQ-015 In IDLE with req nonzero, the block SHALL pick a winner round-robin starting at the index after the last served requester (wrapping NUM_REQ-1 -> 0), and go to WAIT.
REQ-016 On the cycle after a request is sampled in IDLE, the block SHALL drive grant one-hot on the winner, mem_start=1 for exactly one cycle, and mem_num_of_dat = the winner's req_len latched at the sampling edge.
REQ-017 In WAIT the block SHALL ignore changes to req and req_len; a dropped req SHALL NOT abort the burst.
REQ-018 On mem_done in WAIT, the block SHALL pulse req_done[winner] for one cycle on the next cycle, deassert grant on that same cycle, update the last-served pointer, and go to GAP.
REQ-019 GAP SHALL last exactly one cycle before IDLE, giving at least one idle cycle between mem_start pulses.
REQ-020 mem_done outside WAIT SHALL be ignored.
REQ-021 A requester holding req SHALL be served again only after every other active requester has been served once.
REQ-022 Back-to-back minimum spacing SHALL be mem_done -> next mem_start = 3 cycles when another request is pending.

Reset
REQ-023 While rst is high, the block SHALL drive grant, req_done, mem_start, mem_num_of_dat, busy and timeout_err to 0, and hold the FSM in IDLE.
REQ-024 While rst is high, the last-served pointer SHALL be NUM_REQ-1, so that requester 0 has first priority.
REQ-025 Reset asserted mid-burst SHALL abandon the burst without a req_done pulse.

Configuration
REQ-026 With macro MEM_IN_SCHED_TIMEOUT_EN defined, a WAIT-cycle counter SHALL run; if it reaches 2^log2_DEPTH+4 without mem_done, the block SHALL set timeout_err, pulse req_done[winner], and go to GAP.
REQ-027 timeout_err SHALL stay set until rst.
REQ-028 With MEM_IN_SCHED_TIMEOUT_EN undefined, there SHALL be no counter, timeout_err SHALL be tied 0, and WAIT SHALL wait indefinitely.

Verification
REQ-029 Single request: req=4'b0001 and len0=5 at cycle 0 -> at cycle 1 mem_start=1, grant=0001, mem_num_of_dat=5; mem_done at cycle 8 -> req_done=0001 at cycle 9.
REQ-030 Contention: req=4'b1111 held throughout -> grants SHALL follow 0001, 0010, 0100, 1000, 0001.
REQ-031 Pointer wrap: requester 3 is served, then req=4'b1001 -> requester 0 SHALL be granted next.
REQ-032 Requester 1 drops req mid-WAIT -> burst completes and req_done[1] pulses; a glitch on mem_done during GAP/IDLE -> no effect.
REQ-033 rst pulsed during WAIT -> all outputs 0 immediately; the next req=4'b0110 SHALL grant requester 1.
REQ-034 With MEM_IN_SCHED_TIMEOUT_EN defined, log2_DEPTH=3 and mem_done withheld -> after 12 WAIT cycles timeout_err=1 and req_done pulses; timeout_err stays 1 until rst.

Source files
------------

// File: rtl/mem_in_burst_scheduler.sv
// Round-robin arbiter sharing one input-memory burst reader among NUM_REQ requesters.
// Latency: mem_start/grant one cycle after req is sampled in IDLE; req_done one cycle after mem_done.
// Backpressure: a granted burst holds the reader until mem_done; a GAP cycle follows every burst.
// Optional feature: define MEM_IN_SCHED_TIMEOUT_EN to enable the WAIT watchdog and timeout_err.
module mem_in_burst_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int log2_DEPTH = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*log2_DEPTH-1:0]    req_len,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               req_done,
    output logic                             mem_start,
    output logic [log2_DEPTH-1:0]            mem_num_of_dat,
    input  logic                             mem_done,
    output logic                             busy,
    output logic                             timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic [NUM_REQ-1:0]    grant_q,     grant_d;
    logic [NUM_REQ-1:0]    req_done_q,  req_done_d;
    logic                  mem_start_q, mem_start_d;
    logic [log2_DEPTH-1:0] len_q,       len_d;
    logic                  busy_q,      busy_d;
    logic [PTR_W-1:0]      owner_q,     owner_d;
    logic [PTR_W-1:0]      last_q,      last_d;

    logic                  rr_found;
    logic [PTR_W-1:0]      rr_idx;
    logic [PTR_W:0]        cand;
    logic                  timeout_hit;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!rr_found && req[cand[PTR_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/WAIT/GAP controller.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        req_done_d  = '0;
        mem_start_d = 1'b0;
        len_d       = len_q;
        owner_d     = owner_q;
        last_d      = last_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    state_d     = ST_WAIT;
                    grant_d     = NUM_REQ'(1) << rr_idx;
                    mem_start_d = 1'b1;
                    len_d       = req_len[rr_idx*log2_DEPTH +: log2_DEPTH];
                    owner_d     = rr_idx;
                end
            end
            ST_WAIT: begin
                // req/req_len are deliberately ignored here; only the reader ends a burst.
                if (mem_done || timeout_hit) begin
                    state_d    = ST_GAP;
                    grant_d    = '0;
                    req_done_d = NUM_REQ'(1) << owner_q;
                    last_d     = owner_q;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Controller state and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            req_done_q  <= '0;
            mem_start_q <= 1'b0;
            len_q       <= '0;
            busy_q      <= 1'b0;
            owner_q     <= '0;
            last_q      <= PTR_W'(NUM_REQ-1);
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            req_done_q  <= req_done_d;
            mem_start_q <= mem_start_d;
            len_q       <= len_d;
            busy_q      <= busy_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
        end
    end

`ifdef MEM_IN_SCHED_TIMEOUT_EN
    // Watchdog fires after this many WAIT cycles without mem_done.
    localparam int TO_LIMIT = (1 << log2_DEPTH) + 4;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_err_q, timeout_err_d;

    // WAIT-cycle counter, cleared on every burst start; the error flag is sticky.
    always_comb begin
        to_cnt_d      = to_cnt_q;
        timeout_hit   = (state_q == ST_WAIT) && !mem_done &&
                        (to_cnt_q == TO_W'(TO_LIMIT - 1));
        timeout_err_d = timeout_err_q | timeout_hit;
        if (state_q == ST_IDLE) begin
            to_cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign grant          = grant_q;
    assign req_done       = req_done_q;
    assign mem_start      = mem_start_q;
    assign mem_num_of_dat = len_q;
    assign busy           = busy_q;

endmodule
